mem_ctrl: RTL
=============

Name: mem_ctrl

Overview:
Byte-serial memory controller between the core and the single-port, 8-bit-wide unified RAM. It shares the RAM between two requesters: instruction-cache line fills (16 bytes) and load/store unit accesses (1, 2 or 4 bytes). It sequences one multi-byte transfer at a time and returns assembled data with a one-cycle done pulse. It also handles rollback and stalls on the I/O write buffer.

Parameters:
LINE_BYTES, 16, bytes per icache line fill; fc_line width is 8*LINE_BYTES.
IO_ADDR_HI, 2'b11, value of addr[17:16] that marks a memory-mapped I/O address.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
rdy  input  1  global ready; low freezes the block
rb  input  1  rollback; aborts read transfers
fc_ena  input  1  icache fill request, held until fc_done
fc_addr  input  32  line base address, 16-byte aligned
fc_done  output  1  one-cycle pulse, fc_line valid
fc_line  output  128  fetched line, byte k at bits [8k+7:8k]
ls_ena  input  1  LSB request, held until ls_done
ls_wr  input  1  1=store, 0=load
ls_addr  input  32  start byte address
ls_len  input  2  0=1B, 1=2B, 3=4B (2 is illegal)
ls_wdata  input  32  store data, little-endian, low bytes used
ls_done  output  1  one-cycle pulse, ls_rdata valid for loads
ls_rdata  output  32  load data, zero-extended, little-endian
mem_din  input  8  RAM read byte
mem_dout  output  8  RAM write byte
mem_a  output  32  RAM byte address
mem_wr  output  1  RAM write strobe, 1=write
io_buffer_full  input  1  I/O output buffer full

Behaviour:
- Reset: state IDLE; fc_done, ls_done, mem_wr = 0; mem_a, mem_dout, fc_line, ls_rdata, counters = 0; the round-robin pointer selects LSB first. All outputs are registered.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - Sample fc_ena and ls_ena at each edge and grant one requester.
  - Latch the base address, N (16, or ls_len+1) and the owner.
  - On the accept edge, drive mem_a = base.
  - Go to READ for a fill or load; go to WRITE for a store.
- RAM read latency: the byte addressed in cycle c appears on mem_din in cycle c+1.
- READ timing:
  - The issue pointer advances by one each edge, mem_a = base+k.
  - The byte at offset k is captured at edge E(k+2), where E0 is the accept edge.
  - The last byte is captured at E(N+1), with the transition to DONE on the same edge.
  - mem_wr stays 0 throughout.
- WRITE timing:
  - From E(k) to E(k+1): mem_a = base+k, mem_dout = byte k, mem_wr = 1.
  - After the last byte, go to DONE at E(N) with mem_wr = 0.
- I/O write stall: if addr[17:16] == IO_ADDR_HI and io_buffer_full = 1 when byte k is due:
  - Drive mem_wr = 0 and hold k.
  - Issue byte k on the first edge with io_buffer_full = 0.
- DONE:
  - The owner's done output is high for exactly this one cycle.
  - Requests are ignored, so a requester that lowers ena on this edge is not re-granted.
  - Next state is IDLE.
- Address arithmetic is mod 2^32; base+k wraps.
- rdy low:
  - All state, counters and data registers hold; mem_wr is forced 0.
  - On resume in READ, the issue pointer reloads from the capture pointer, so uncaptured bytes are re-issued.
  - In WRITE, the held byte is re-issued on resume.
- rb high (takes precedence over everything except rst):
  - In READ or DONE of a fill or load: go to IDLE, suppress done, set mem_wr = 0.
  - WRITE completes normally, since a committed store is never dropped.
  - In IDLE, requests presented with rb are not granted.
- Reset mid-transfer: the transfer is abandoned; no done.
- ls_len = 2 is treated as 4 bytes. A bench assertion flags it.

Optional Feature:
MEM_CTRL_RR_EN
- Defined: round-robin arbitration. After a grant, the other requester has priority at the next simultaneous request.
- Undefined: fixed priority, LSB over icache. The pointer register is not built.

Test Plan:
1. Line fill: RAM[0x100+k] = k, fc_ena with fc_addr = 0x100 → fc_done is a single-cycle pulse 17 edges after accept; fc_line = 0x0F0E0D0C0B0A09080706050403020100.
2. Word load: RAM[0x200..0x203] = 78 56 34 12, ls_len = 3 → ls_done after 5 edges; ls_rdata = 0x12345678. A byte load from 0x201 → 0x00000056.
3. Halfword store: 0xBEEF to 0x300 → mem_wr = 1 for exactly 2 cycles with (0x300, EF), (0x301, BE); ls_done on the next cycle. Readback gives 0xBEEF.
4. Simultaneous fc_ena and ls_ena from reset:
   - With MEM_CTRL_RR_EN, the LSB is served first, then the icache, then the LSB on a repeat collision.
   - Without it, the LSB always wins.
   - A requester dropping ena in DONE is never re-granted.
5. I/O stall: 1-byte store to 0x30000 with io_buffer_full high for 3 cycles → mem_wr is held 0 for 3 cycles, then one write, then ls_done.
6. Abort and freeze:
   - rb during fill byte 7 → no fc_done, IDLE next cycle; a following load is served correctly.
   - rdy low for 4 cycles mid word-load → same ls_rdata as in scenario 2.

Source files
------------

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial unified RAM controller for icache fills and LSU accesses
//
// Shares one 8-bit single-port RAM between icache line fills (LINE_BYTES)
// and load/store unit accesses (1, 2 or 4 bytes). One transfer runs at a
// time; assembled data is returned with a one-cycle done pulse.
//
// Optional feature macro: MEM_CTRL_RR_EN
//   defined   : round-robin arbitration between the two requesters
//   undefined : fixed priority, LSU over icache (no pointer register)
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   rdy             global ready, low freezes the block
//   rb              rollback, aborts fills and loads
//   fc_ena/fc_addr  icache fill request and line base address
//   fc_done/fc_line fill complete pulse and fetched line
//   ls_ena/ls_wr    LSU request, 1=store 0=load
//   ls_addr/ls_len  start byte address, length code (0=1B 1=2B 3=4B)
//   ls_wdata        store data, little-endian
//   ls_done/ls_rdata LSU complete pulse and zero-extended load data
//   mem_din         RAM read byte (one cycle after mem_a)
//   mem_dout/mem_a/mem_wr RAM write byte, byte address, write strobe
//   io_buffer_full  I/O output buffer full, stalls I/O stores
module mem_ctrl #(
   parameter int         LINE_BYTES = 16,
   parameter logic [1:0] IO_ADDR_HI = 2'b11
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    rdy,
   input  logic                    rb,
   input  logic                    fc_ena,
   input  logic [31:0]             fc_addr,
   output logic                    fc_done,
   output logic [8*LINE_BYTES-1:0] fc_line,
   input  logic                    ls_ena,
   input  logic                    ls_wr,
   input  logic [31:0]             ls_addr,
   input  logic [1:0]              ls_len,
   input  logic [31:0]             ls_wdata,
   output logic                    ls_done,
   output logic [31:0]             ls_rdata,
   input  logic [7:0]              mem_din,
   output logic [7:0]              mem_dout,
   output logic [31:0]             mem_a,
   output logic                    mem_wr,
   input  logic                    io_buffer_full
);

   localparam int CW = $clog2(LINE_BYTES + 1);
   localparam int LW = 8 * LINE_BYTES;

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   state_t        state;
   logic          own_fc;
   logic [31:0]   base;
   logic [CW-1:0] nbytes;
   // Offset currently presented on mem_a; for stores iss_vld means the
   // strobe for that offset is being driven this cycle.
   logic [CW-1:0] iss_off;
   logic          iss_vld;
   // Next byte to capture; bytes arrive in order so mem_din always holds
   // byte cap_ptr when din_vld is set.
   logic [CW-1:0] cap_ptr;
   logic          din_vld;
   // Set while frozen in READ so the first active edge re-issues from cap_ptr.
   logic          frozen;
   logic [LW-1:0] line_buf;
   logic [31:0]   wdata;

   logic          pick_fc;
   logic [CW-1:0] ls_n;
   logic [CW-1:0] iss_nxt;
   logic [CW-1:0] wr_k;
   logic [31:0]   wr_a;
   logic          wr_stall;
   logic          acc_stall;
   logic [LW-1:0] cap_line;

`ifdef MEM_CTRL_RR_EN
   logic rr_fc;  // 1: icache wins the next collision
   assign pick_fc = fc_ena && (!ls_ena || rr_fc);
`else
   assign pick_fc = fc_ena && !ls_ena;
`endif

   always_comb begin
      // Length code 2 is illegal and is handled as a word.
      ls_n      = (ls_len == 2'd2) ? CW'(4) : CW'(ls_len) + CW'(1);
      iss_nxt   = iss_off + CW'(1);
      // Store byte due at the coming edge: the next one after a completed
      // strobe, otherwise the held one.
      wr_k      = iss_vld ? iss_nxt : iss_off;
      wr_a      = base + 32'(wr_k);
      wr_stall  = (wr_a[17:16] == IO_ADDR_HI) && io_buffer_full;
      acc_stall = (ls_addr[17:16] == IO_ADDR_HI) && io_buffer_full;
      // Buffer including the byte captured at this edge, so the final byte
      // reaches fc_line/ls_rdata on the same edge that enters DONE.
      cap_line  = line_buf;
      cap_line[8*cap_ptr +: 8] = mem_din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         own_fc   <= 1'b0;
         base     <= '0;
         nbytes   <= '0;
         iss_off  <= '0;
         iss_vld  <= 1'b0;
         cap_ptr  <= '0;
         din_vld  <= 1'b0;
         frozen   <= 1'b0;
         line_buf <= '0;
         wdata    <= '0;
         fc_done  <= 1'b0;
         fc_line  <= '0;
         ls_done  <= 1'b0;
         ls_rdata <= '0;
         mem_a    <= '0;
         mem_dout <= '0;
         mem_wr   <= 1'b0;
`ifdef MEM_CTRL_RR_EN
         rr_fc    <= 1'b0;
`endif
      end else if (rb && (state == READ || state == DONE)) begin
         // Rollback drops reads; a store in WRITE is already committed.
         state   <= IDLE;
         fc_done <= 1'b0;
         ls_done <= 1'b0;
         mem_wr  <= 1'b0;
         iss_vld <= 1'b0;
         din_vld <= 1'b0;
         frozen  <= 1'b0;
      end else if (!rdy) begin
         mem_wr <= 1'b0;
         if (state == READ)
            frozen <= 1'b1;
         if (state == WRITE)
            iss_vld <= 1'b0;  // re-issue the held byte on resume
      end else begin
         case (state)
            IDLE: begin
               if (!rb && (fc_ena || ls_ena)) begin
                  own_fc   <= pick_fc;
                  base     <= pick_fc ? fc_addr : ls_addr;
                  mem_a    <= pick_fc ? fc_addr : ls_addr;
                  nbytes   <= pick_fc ? CW'(LINE_BYTES) : ls_n;
                  wdata    <= ls_wdata;
                  line_buf <= '0;
                  cap_ptr  <= '0;
                  iss_off  <= '0;
                  din_vld  <= 1'b0;
                  frozen   <= 1'b0;
`ifdef MEM_CTRL_RR_EN
                  rr_fc    <= !pick_fc;
`endif
                  if (!pick_fc && ls_wr) begin
                     state    <= WRITE;
                     mem_dout <= ls_wdata[7:0];
                     mem_wr   <= !acc_stall;
                     iss_vld  <= !acc_stall;
                  end else begin
                     state   <= READ;
                     mem_wr  <= 1'b0;
                     iss_vld <= 1'b1;
                  end
               end
            end

            READ: begin
               if (frozen) begin
                  frozen  <= 1'b0;
                  iss_off <= cap_ptr;
                  mem_a   <= base + 32'(cap_ptr);
                  iss_vld <= 1'b1;
                  din_vld <= 1'b0;
               end else begin
                  if (din_vld) begin
                     line_buf <= cap_line;
                     cap_ptr  <= cap_ptr + CW'(1);
                     if (cap_ptr == nbytes - CW'(1)) begin
                        state <= DONE;
                        if (own_fc) begin
                           fc_done <= 1'b1;
                           fc_line <= cap_line;
                        end else begin
                           ls_done  <= 1'b1;
                           ls_rdata <= cap_line[31:0];
                        end
                     end
                  end
                  din_vld <= iss_vld;
                  if (iss_vld) begin
                     if (iss_off == nbytes - CW'(1)) begin
                        iss_vld <= 1'b0;
                     end else begin
                        iss_off <= iss_nxt;
                        mem_a   <= base + 32'(iss_nxt);
                     end
                  end
               end
            end

            WRITE: begin
               if (iss_vld && iss_off == nbytes - CW'(1)) begin
                  state   <= DONE;
                  mem_wr  <= 1'b0;
                  iss_vld <= 1'b0;
                  ls_done <= 1'b1;
               end else begin
                  iss_off <= wr_k;
                  if (wr_stall) begin
                     mem_wr  <= 1'b0;
                     iss_vld <= 1'b0;
                  end else begin
                     mem_wr   <= 1'b1;
                     mem_a    <= wr_a;
                     mem_dout <= wdata[8*wr_k[1:0] +: 8];
                     iss_vld  <= 1'b1;
                  end
               end
            end

            DONE: begin
               state   <= IDLE;
               fc_done <= 1'b0;
               ls_done <= 1'b0;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
